// File: rtl/alu_rr_arbiter_if.sv
// Request/result bundle between two requesters, the shared-ALU arbiter and
// the result consumer.
interface alu_rr_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic [1:0] req0_op;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic [1:0] req1_op;
    logic       req1_ready;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res;
    logic       res_id;
    logic       res_zero;
    logic       busy;

    // Requesters and consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output res_ready,
        input  req0_ready, req1_ready, res_valid, res, res_id, res_zero, busy
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  res_ready,
        output req0_ready, req1_ready, res_valid, res, res_id, res_zero, busy
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Two-channel round-robin arbiter sharing one 8-bit ALU. A granted request is
// latched in IDLE, evaluated in EXEC, and its tagged result is held in DONE
// until the consumer takes it.
module alu_rr_arbiter #(
    parameter bit PRIO_RESET = 1'b0
) (
    input logic             clk,
    input logic             rst_n,
    alu_rr_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t     state_q;
    logic       ptr_q;
    logic [7:0] a_q, b_q;
    logic [1:0] op_q;
    logic       id_q;
    logic [7:0] res_q;
    logic       res_id_q;
    logic       res_zero_q;

    logic       gnt_vld;
    logic       gnt_id;
    logic       accept;
    logic [7:0] alu_d;

    // Grant: a lone valid wins outright; under contention ptr decides.
    always_comb begin
        gnt_vld = bus.req0_valid | bus.req1_valid;
        gnt_id  = (bus.req0_valid & bus.req1_valid) ? ptr_q : bus.req1_valid;
        accept  = (state_q == IDLE) & gnt_vld & rst_n;
    end

    assign bus.req0_ready = accept & ~gnt_id;
    assign bus.req1_ready = accept &  gnt_id;
    assign bus.res_valid  = (state_q == DONE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.res        = res_q;
    assign bus.res_id     = res_id_q;
    assign bus.res_zero   = res_zero_q;

    // ALU on latched operands; results wrap modulo 256.
    always_comb begin
        alu_d = 8'h00;
        case (op_q)
            2'b00: alu_d = a_q + b_q;
            2'b01: alu_d = a_q - b_q;
            2'b10: alu_d = a_q ^ b_q;
            2'b11: alu_d = {a_q[6:0], 1'b0};
            default: alu_d = 8'h00;
        endcase
    end

    // Sequencer: latch on accept, register result leaving EXEC, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= PRIO_RESET;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            op_q       <= 2'b00;
            id_q       <= 1'b0;
            res_q      <= 8'h00;
            res_id_q   <= 1'b0;
            res_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        a_q     <= gnt_id ? bus.req1_a  : bus.req0_a;
                        b_q     <= gnt_id ? bus.req1_b  : bus.req0_b;
                        op_q    <= gnt_id ? bus.req1_op : bus.req0_op;
                        id_q    <= gnt_id;
                        ptr_q   <= ~gnt_id;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    res_q      <= alu_d;
                    res_id_q   <= id_q;
                    res_zero_q <= (alu_d == 8'h00);
                    state_q    <= DONE;
                end
                DONE: begin
                    if (bus.res_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: reset, single op, contention, back-pressure,
// wrap-around, lone requester and reset in the middle of an operation.
module tb_alu_rr_arbiter;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    alu_rr_arbiter_if bus ();

    alu_rr_arbiter #(.PRIO_RESET(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = 8'h00; bus.req0_b = 8'h00; bus.req0_op = 2'b00;
        bus.req1_valid = 1'b0; bus.req1_a = 8'h00; bus.req1_b = 8'h00; bus.req1_op = 2'b00;
        bus.res_ready  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_res"},      bus.res,        8'h00);
        chk({tag, "_res_id"},   bus.res_id,     1'b0);
        chk({tag, "_zero"},     bus.res_zero,   1'b0);
        chk({tag, "_res_vld"},  bus.res_valid,  1'b0);
        chk({tag, "_busy"},     bus.busy,       1'b0);
        chk({tag, "_rdy0"},     bus.req0_ready, 1'b0);
        chk({tag, "_rdy1"},     bus.req1_ready, 1'b0);
    endtask

    // One lone-requester operation with immediate consumer acceptance.
    task automatic do_op(input string tag, input bit ch, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] op, input logic [7:0] er);
        if (ch) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
        #1;
        chk({tag, "_rdy"},   ch ? bus.req1_ready : bus.req0_ready, 1'b1);
        chk({tag, "_rdy_o"}, ch ? bus.req0_ready : bus.req1_ready, 1'b0);
        tick();                                   // accept edge
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        chk({tag, "_exec_busy"}, bus.busy,      1'b1);
        chk({tag, "_exec_vld"},  bus.res_valid, 1'b0);
        tick();                                   // result registered
        chk({tag, "_vld"},  bus.res_valid, 1'b1);
        chk({tag, "_res"},  bus.res,       er);
        chk({tag, "_id"},   bus.res_id,    ch);
        chk({tag, "_zero"}, bus.res_zero,  (er == 8'h00));
        bus.res_ready = 1'b1;
        tick();                                   // handshake edge
        chk({tag, "_done_vld"},  bus.res_valid, 1'b0);
        chk({tag, "_done_busy"}, bus.busy,      1'b0);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk_all_zero("rst");
        tick();
        rst_n = 1'b1;
        tick();
        chk_all_zero("post_rst");

        // Contention: ch0 add 1+2=3, ch1 sub 9-4=5, both held valid throughout.
        bus.req0_valid = 1'b1; bus.req0_a = 8'h01; bus.req0_b = 8'h02; bus.req0_op = 2'b00;
        bus.req1_valid = 1'b1; bus.req1_a = 8'h09; bus.req1_b = 8'h04; bus.req1_op = 2'b01;
        bus.res_ready  = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("cont_rdy0", bus.req0_ready, (k % 2 == 0));
            chk("cont_rdy1", bus.req1_ready, (k % 2 == 1));
            tick();
            chk("cont_exec_rdy", {bus.req0_ready, bus.req1_ready}, 2'b00);
            tick();
            chk("cont_id",  bus.res_id, (k % 2 == 1));
            chk("cont_res", bus.res,    (k % 2 == 1) ? 8'h05 : 8'h03);
            tick();
        end
        idle_inputs();

        // Single op (ptr back at 0 after the even number of contended grants).
        do_op("single", 1'b0, 8'h3C, 8'h14, 2'b00, 8'h50);

        // Back-pressure: ch1 xor held in DONE for 5 cycles, ch0 pending meanwhile.
        bus.req1_valid = 1'b1; bus.req1_a = 8'hA5; bus.req1_b = 8'h5A; bus.req1_op = 2'b10;
        #1;
        chk("bp_rdy1", bus.req1_ready, 1'b1);
        tick();
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 8'h11; bus.req0_b = 8'h22; bus.req0_op = 2'b00;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_vld", bus.res_valid, 1'b1);
            chk("bp_res", bus.res,       8'hFF);
            chk("bp_id",  bus.res_id,    1'b1);
            chk("bp_rdy", {bus.req0_ready, bus.req1_ready}, 2'b00);
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.res_ready  = 1'b1;
        #1;
        chk("bp_hold_vld", bus.res_valid, 1'b1);
        tick();
        chk("bp_done_vld",  bus.res_valid, 1'b0);
        chk("bp_done_busy", bus.busy,      1'b0);
        bus.res_ready = 1'b0;

        // Wrap-around and zero flag; the last op is a lone ch1 with ptr=0.
        do_op("add_wrap", 1'b0, 8'hFF, 8'h01, 2'b00, 8'h00);   // ptr -> 1
        do_op("shl",      1'b1, 8'h81, 8'h00, 2'b11, 8'h02);   // ptr -> 0
        do_op("sub_wrap", 1'b1, 8'h00, 8'h01, 2'b01, 8'hFF);   // lone ch1, ptr stays 0

        // ptr must be 0: contention grants ch0. Drop valids before the edge.
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        chk("ptr_rdy0", bus.req0_ready, 1'b1);
        chk("ptr_rdy1", bus.req1_ready, 1'b0);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tick();
        chk("ptr_no_accept", bus.busy, 1'b0);

        // Reset during EXEC after a ch0 accept (which moved ptr to 1).
        bus.req0_valid = 1'b1; bus.req0_a = 8'h01; bus.req0_b = 8'h01; bus.req0_op = 2'b00;
        #1;
        tick();
        bus.req0_valid = 1'b0;
        chk("mid_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("stale_vld",  bus.res_valid, 1'b0);
        chk("stale_busy", bus.busy,      1'b0);
        chk("stale_res",  bus.res,       8'h00);
        bus.req0_valid = 1'b1; bus.req0_a = 8'h10; bus.req0_b = 8'h20; bus.req0_op = 2'b00;
        bus.req1_valid = 1'b1; bus.req1_a = 8'h30; bus.req1_b = 8'h30; bus.req1_op = 2'b10;
        #1;
        chk("prio_rdy0", bus.req0_ready, 1'b1);
        chk("prio_rdy1", bus.req1_ready, 1'b0);
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tick();
        chk("prio_vld", bus.res_valid, 1'b1);
        chk("prio_id",  bus.res_id,    1'b0);
        chk("prio_res", bus.res,       8'h30);
        bus.res_ready = 1'b1;
        tick();
        chk("prio_done", bus.res_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
